// File: rtl/mem_port_arbiter.sv
// Single-port cache arbiter that grants either a load or a committed store, then holds the
// request until the cache acks. Stores are forced after STARVE_LIMIT loads have bypassed them.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_LEN     = 32,
  parameter int ROB_SEL      = 6,
  parameter int DATA_LEN     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_req,
  input  logic [ADDR_LEN-1:0] ld_addr,
  input  logic [ROB_SEL-1:0]  ld_rob_idx,
  output logic                ld_grant,
  input  logic                st_req,
  input  logic [ADDR_LEN-1:0] st_addr,
  input  logic [DATA_LEN-1:0] st_data,
  output logic                st_grant,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                ld_done,
  output logic [ROB_SEL-1:0]  ld_done_rob_idx,
  output logic [DATA_LEN-1:0] ld_done_data,
  output logic                st_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt;
  logic               drop;
  logic [ROB_SEL-1:0] rob_q;
  logic               limit_hit;
  logic               ld_live;

  assign limit_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // A flushed load no longer competes, so a waiting store may go regardless of the counter.
  assign ld_live   = ld_req && !flush;
  assign busy      = (state != IDLE);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    ld_grant  = 1'b0;
    st_grant  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (reset) begin
          if (st_req && (!ld_live || limit_hit)) begin
            st_grant  = 1'b1;
            state_nxt = STORE;
          end else if (ld_live) begin
            ld_grant  = 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      LOAD, STORE: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt      <= '0;
      drop            <= 1'b0;
      rob_q           <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      ld_done         <= 1'b0;
      ld_done_rob_idx <= '0;
      ld_done_data    <= '0;
      st_done         <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      st_done <= 1'b0;
      if (st_grant) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b1;
        mem_addr   <= st_addr;
        mem_wdata  <= st_data;
        starve_cnt <= '0;
      end else if (ld_grant) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= ld_addr;
        rob_q    <= ld_rob_idx;
        if (st_req && !limit_hit) starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == LOAD && flush) drop <= 1'b1;
      // The ack edge also sees flush, so a squash in that very cycle still drops the result.
      if (state != IDLE && mem_ack) begin
        mem_req <= 1'b0;
        drop    <= 1'b0;
        if (state == STORE) begin
          st_done <= 1'b1;
        end else if (!(drop || flush)) begin
          ld_done         <= 1'b1;
          ld_done_rob_idx <= rob_q;
          ld_done_data    <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive load grants allowed over a pending store before the store is forced.
REQ-002 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- ld_req  in  1  load queue head ready to issue
- ld_addr  in  ADDR_LEN  load address
- ld_rob_idx  in  ROB_SEL  ROB index of the load
- ld_grant  out  1  load accepted this cycle (combinational)
- st_req  in  1  committed store ready to drain
- st_addr  in  ADDR_LEN  store address
- st_data  in  DATA_LEN  store data
- st_grant  out  1  store accepted this cycle (combinational)
- flush  in  1  pipeline squash; discard load results
- mem_req  out  1  cache port request, registered
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  ADDR_LEN  request address
- mem_wdata  out  DATA_LEN  store data
- mem_ack  in  1  cache completes the current request
- mem_rdata  in  DATA_LEN  load data, valid with mem_ack
- ld_done  out  1  one-cycle pulse: load result valid
- ld_done_rob_idx  out  ROB_SEL  ROB index of the completed load
- ld_done_data  out  DATA_LEN  load data
- st_done  out  1  one-cycle pulse: store written
- busy  out  1  state != IDLE
REQ-003 SHALL take widths ADDR_LEN, ROB_SEL, DATA_LEN from constants.vh.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, STORE.
REQ-005 In IDLE, SHALL assert at most one grant per cycle, and no grant outside IDLE.
REQ-006 SHALL grant the store when st_req=1 and either ld_req=0 or starve_cnt==STARVE_LIMIT.
REQ-007 Otherwise SHALL grant the load when ld_req=1 and flush=0; flush=1 SHALL block only the load grant.
REQ-008 On grant, SHALL capture address, data/rob_idx and mem_we, and enter LOAD or STORE; mem_req SHALL rise the next cycle.
REQ-009 SHALL hold mem_req and all mem_* outputs stable until the cycle mem_ack=1 is sampled.
REQ-010 On the edge sampling mem_ack=1, SHALL return to IDLE and drop mem_req.
REQ-011 On that same edge, SHALL register a one-cycle ld_done (LOAD) or st_done (STORE); ld_done_data SHALL equal mem_rdata at the ack cycle.
REQ-012 Minimum latency: grant at cycle T, mem_req at T+1, ack at T+1 gives done at T+2, and a new grant is possible at T+2.
REQ-013 SHALL ignore mem_ack in IDLE.
REQ-014 starve_cnt:
- increment, saturating at STARVE_LIMIT, when a load is granted while st_req=1
- clear on store grant
- hold otherwise
REQ-015 Flush handling:
- SHALL set a drop flag if flush=1 in the load-grant cycle or at any cycle in LOAD.
- A dropped load SHALL still wait for mem_ack and SHALL suppress ld_done.
- The drop flag SHALL clear on return to IDLE.
REQ-016 SHALL never let flush affect an accepted store.
REQ-017 ld_done_rob_idx and ld_done_data SHALL hold their last values when ld_done=0.

Reset
REQ-018 With reset=0 at a rising edge, SHALL go to IDLE and clear starve_cnt, the drop flag, mem_req, mem_we, ld_done and st_done.
REQ-019 During reset, SHALL clear mem_addr, mem_wdata, ld_done_rob_idx and ld_done_data to 0.
REQ-020 SHALL force ld_grant=0 and st_grant=0 while reset=0.
REQ-021 Reset mid-transaction SHALL abandon the request with no done pulse; a later stray mem_ack SHALL be ignored.

Verification
REQ-022 Load only: ld_req=1, addr=0x100, rob=5; mem_ack one cycle after mem_req with rdata=0xABCD.
-> ld_grant at T, mem_req=1/mem_we=0/mem_addr=0x100 at T+1, ld_done=1/rob=5/data=0xABCD at T+2.
REQ-023 Starvation: ld_req and st_req held high, ack immediate, STARVE_LIMIT=4.
-> 4 load grants, then 1 store grant with st_done, then the counter restarts.
REQ-024 Flush in LOAD: flush pulsed 1 cycle while waiting; ack 3 cycles later.
-> no ld_done; busy clears after ack; next grant accepted.
REQ-025 Flush with both requests pending in IDLE: flush=1, ld_req=1, st_req=0.
-> no grant; flush=1, ld_req=1, st_req=1 -> st_grant=1.
REQ-026 Reset in STORE: reset=0 for 1 cycle before ack, then ack arrives.
-> mem_req=0, no st_done, state IDLE, starve_cnt=0.
REQ-027 Back-to-back: ld_req held, ack immediate.
-> a grant every 2 cycles; mem_addr is never changed while mem_req=1.
